// File: rtl/serial_to_vector_packer_pkg.sv
// Shared types, rate codes and length helpers for the serial-to-vector packer.
// Optional partial-vector flush is controlled by the STV_FLUSH_EN macro in the top.
package stv_pkg;

    localparam int STV_RATE_W = 4;

    // 802.11a SIGNAL RATE field codes
    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } stv_phase_t;

    // Raw segment lengths {len_a, len_b} for a rate code, before clamping
    function automatic logic [7:0] stv_rate_lens(input logic [3:0] rate);
        logic [7:0] lens;
        if (rate == RATE_24M) lens = {4'd2, 4'd1};
        else                  lens = {4'd2, 4'd2};
        return lens;
    endfunction

    // A zero length still needs one bit per group; nothing wider than the vector fits
    function automatic logic [7:0] stv_clamp_len(input logic [3:0] len, input int max_w);
        int l;
        l = int'(len);
        if (l == 0)    l = 1;
        if (l > max_w) l = max_w;
        return 8'(l);
    endfunction

endpackage

// File: rtl/serial_to_vector_packer_if.sv
// Bit-side and vector-side handshake bundle of the serial-to-vector packer.
// master = upstream/downstream environment, slave = the packer itself.
interface serial_to_vector_packer_if #(
    parameter int MAX_W = 2
);
    localparam int LEN_W = $clog2(MAX_W + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [MAX_W-1:0] vec_out;
    logic [LEN_W-1:0] vec_len;
    logic             vec_valid;
    logic             vec_ready;

    modport master (
        output bit_in, bit_valid, vec_ready,
        input  bit_ready, vec_out, vec_len, vec_valid
    );

    modport slave (
        input  bit_in, bit_valid, vec_ready,
        output bit_ready, vec_out, vec_len, vec_valid
    );

endinterface

// File: rtl/serial_to_vector_packer_out_reg.sv
// Single-entry valid/ready output register holding a packed vector and its length.
// The caller only loads when 'free' is high, so a held vector is never overwritten.
module stv_out_reg #(
    parameter int MAX_W = 2,
    parameter int LEN_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [MAX_W-1:0] load_vec,
    input  logic [LEN_W-1:0] load_len,
    input  logic             vec_ready,
    output logic [MAX_W-1:0] vec_out,
    output logic [LEN_W-1:0] vec_len,
    output logic             vec_valid,
    output logic             free
);

    // Slot is usable this cycle if empty or being drained
    assign free = !vec_valid || vec_ready;

    // Capture a new vector, or drop valid once the held one is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_out   <= '0;
            vec_len   <= '0;
            vec_valid <= 1'b0;
        end else if (load) begin
            vec_out   <= load_vec;
            vec_len   <= load_len;
            vec_valid <= 1'b1;
        end else if (vec_ready) begin
            vec_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_to_vector_packer.sv
// Packs a serial coded bit stream into vectors whose lengths alternate A,B
// according to the latched rate. Build with STV_FLUSH_EN defined to add the
// flush port that emits a partial group early.
module serial_to_vector_packer
    import stv_pkg::*;
#(
    parameter int MAX_W  = 2,
    parameter int RATE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [RATE_W-1:0]          rate,
    input  logic                       frame_start,
`ifdef STV_FLUSH_EN
    input  logic                       flush,
`endif
    serial_to_vector_packer_if.slave   bus
);

    localparam int LEN_W = $clog2(MAX_W + 1);

    logic [MAX_W-1:0] acc_q, base_acc, acc_new, ins, nxt_acc, load_vec;
    logic [LEN_W-1:0] cnt_q, base_cnt, cnt_new, nxt_cnt, load_len;
    logic [LEN_W-1:0] len_a_q, len_b_q, live_a, live_b, eff_a, eff_b, cur_len;
    stv_phase_t       phase_q, base_phase, nxt_phase;
    logic [7:0]       tbl_live;
    logic             relatch, take, done, load, out_free, bit_ready;
`ifdef STV_FLUSH_EN
    logic             pend_q, pend_nxt, flush_req;
`endif

    stv_out_reg #(.MAX_W(MAX_W), .LEN_W(LEN_W)) u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_vec  (load_vec),
        .load_len  (load_len),
        .vec_ready (bus.vec_ready),
        .vec_out   (bus.vec_out),
        .vec_len   (bus.vec_len),
        .vec_valid (bus.vec_valid),
        .free      (out_free)
    );

`ifdef STV_FLUSH_EN
    assign bit_ready = out_free && !pend_q;
`else
    assign bit_ready = out_free;
`endif
    assign bus.bit_ready = bit_ready;

    // Next-state: the live rate table applies at a pair boundary or on frame_start
    always_comb begin
        tbl_live   = stv_rate_lens(STV_RATE_W'(rate));
        live_a     = LEN_W'(stv_clamp_len(tbl_live[7:4], MAX_W));
        live_b     = LEN_W'(stv_clamp_len(tbl_live[3:0], MAX_W));
        relatch    = frame_start || (phase_q == PH_A && cnt_q == '0);
        eff_a      = relatch ? live_a : len_a_q;
        eff_b      = relatch ? live_b : len_b_q;
        base_phase = frame_start ? PH_A : phase_q;
        base_cnt   = frame_start ? '0 : cnt_q;
        base_acc   = frame_start ? '0 : acc_q;
        cur_len    = (base_phase == PH_A) ? eff_a : eff_b;
        take       = bus.bit_valid && bit_ready;
        ins        = take ? (MAX_W'(bus.bit_in) << base_cnt) : '0;
        acc_new    = base_acc | ins;
        cnt_new    = base_cnt + LEN_W'(take);
        done       = take && (cnt_new == cur_len);

        load       = 1'b0;
        load_vec   = acc_new;
        load_len   = cur_len;
        nxt_acc    = acc_new;
        nxt_cnt    = cnt_new;
        nxt_phase  = base_phase;
`ifdef STV_FLUSH_EN
        flush_req  = flush || pend_q;
        pend_nxt   = pend_q;
`endif
        if (done) begin
            load      = 1'b1;
            nxt_acc   = '0;
            nxt_cnt   = '0;
            nxt_phase = (base_phase == PH_A) ? PH_B : PH_A;
`ifdef STV_FLUSH_EN
            pend_nxt  = 1'b0;
        end else if (flush_req) begin
            if (cnt_new == '0) begin
                pend_nxt = 1'b0;
            end else if (out_free) begin
                load      = 1'b1;
                load_len  = cnt_new;
                nxt_acc   = '0;
                nxt_cnt   = '0;
                nxt_phase = PH_A;
                pend_nxt  = 1'b0;
            end else begin
                pend_nxt = 1'b1;
            end
`endif
        end
    end

    // Phase FSM, accumulator, bit count and latched segment lengths
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_A;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_a_q <= LEN_W'(stv_clamp_len(stv_rate_lens(4'b0000) >> 4, MAX_W));
            len_b_q <= LEN_W'(stv_clamp_len(stv_rate_lens(4'b0000) & 8'h0f, MAX_W));
`ifdef STV_FLUSH_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            phase_q <= nxt_phase;
            acc_q   <= nxt_acc;
            cnt_q   <= nxt_cnt;
            if (relatch) begin
                len_a_q <= live_a;
                len_b_q <= live_b;
            end
`ifdef STV_FLUSH_EN
            pend_q  <= pend_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_to_vector_packer.sv
// Directed bench for serial_to_vector_packer; flush steps run when STV_FLUSH_EN is defined.
module tb_serial_to_vector_packer;
    import stv_pkg::*;

    localparam int MAX_W  = 2;
    localparam int RATE_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [RATE_W-1:0] rate;
    logic              frame_start;
`ifdef STV_FLUSH_EN
    logic              flush;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    serial_to_vector_packer_if #(.MAX_W(MAX_W)) bus ();

    serial_to_vector_packer #(.MAX_W(MAX_W), .RATE_W(RATE_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rate        (rate),
        .frame_start (frame_start),
`ifdef STV_FLUSH_EN
        .flush       (flush),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic v);
        bus.bit_in    = b;
        bus.bit_valid = v;
    endtask

    task automatic check_vec(input string tag, input logic [1:0] v, input logic [1:0] l);
        check({tag, "_out"},   32'(bus.vec_out),   32'(v));
        check({tag, "_len"},   32'(bus.vec_len),   32'(l));
        check({tag, "_valid"}, 32'(bus.vec_valid), 32'(1'b1));
    endtask

    initial begin
        reset_n       = 1'b0;
        rate          = RATE_6M;
        frame_start   = 1'b0;
`ifdef STV_FLUSH_EN
        flush         = 1'b0;
`endif
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.vec_ready = 1'b1;
        repeat (2) cyc();
        check("rst_out",   32'(bus.vec_out),   32'(0));
        check("rst_len",   32'(bus.vec_len),   32'(0));
        check("rst_valid", 32'(bus.vec_valid), 32'(0));
        reset_n = 1'b1;
        #1;
        check("rst_bit_ready", 32'(bus.bit_ready), 32'(1));

        // fixed 2,2: bits 1,0,1,1
        drive(1'b1, 1'b1); cyc(); check("fix_b0_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b0, 1'b1); cyc(); check_vec("fix_g0", 2'b01, 2'd2);
        drive(1'b1, 1'b1); cyc(); check("fix_b2_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b1, 1'b1); cyc(); check_vec("fix_g1", 2'b11, 2'd2);

        // stall with a vector held
        bus.vec_ready = 1'b0;
        #1;
        check("bp22_bit_ready", 32'(bus.bit_ready), 32'(0));
        cyc();
        check_vec("bp22_hold", 2'b11, 2'd2);

        // async reset discards the pending vector
        #2 reset_n = 1'b0;
        #1;
        check("rstp_out",   32'(bus.vec_out),   32'(0));
        check("rstp_len",   32'(bus.vec_len),   32'(0));
        check("rstp_valid", 32'(bus.vec_valid), 32'(0));
        cyc();
        reset_n       = 1'b1;
        bus.vec_ready = 1'b1;
        #1;
        check("rstp_bit_ready", 32'(bus.bit_ready), 32'(1));

        // reset mid-group drops the partial bit
        drive(1'b1, 1'b1); cyc();
        #2 reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        drive(1'b0, 1'b1); cyc(); check("rstm_b0_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b1, 1'b1); cyc(); check_vec("rstm_g0", 2'b10, 2'd2);
        drive(1'b0, 1'b0); cyc(); check("rstm_drain", 32'(bus.vec_valid), 32'(0));

        // pattern 2,1: bits 1,1,0,1,0
        rate = RATE_24M; frame_start = 1'b1;
        drive(1'b1, 1'b1); cyc(); frame_start = 1'b0;
        check("p21_b0_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b1, 1'b1); cyc(); check_vec("p21_g0", 2'b11, 2'd2);
        drive(1'b0, 1'b1); cyc(); check_vec("p21_g1", 2'b00, 2'd1);
        drive(1'b1, 1'b1); cyc(); check("p21_b3_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b0, 1'b1); cyc(); check_vec("p21_g2", 2'b01, 2'd2);

        // backpressure, then release with a completing bit in the same cycle
        bus.vec_ready = 1'b0;
        drive(1'b0, 1'b1);
        #1;
        check("bp_bit_ready", 32'(bus.bit_ready), 32'(0));
        cyc(); check_vec("bp_hold", 2'b01, 2'd2);
        bus.vec_ready = 1'b1;
        #1;
        check("bp_rel_bit_ready", 32'(bus.bit_ready), 32'(1));
        cyc(); check_vec("bp_b2b", 2'b00, 2'd1);
        drive(1'b0, 1'b1); cyc();
        drive(1'b1, 1'b1); cyc(); check_vec("bp_next", 2'b10, 2'd2);

        // resync: partial bit dropped, pending vector kept
        drive(1'b0, 1'b0); rate = RATE_6M; frame_start = 1'b1;
        cyc(); frame_start = 1'b0;
        drive(1'b1, 1'b1); cyc();
        frame_start = 1'b1;
        drive(1'b0, 1'b1); cyc(); frame_start = 1'b0;
        check("rs_b0_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b1, 1'b1); cyc(); check_vec("rs_g0", 2'b10, 2'd2);
        bus.vec_ready = 1'b0; drive(1'b0, 1'b0); frame_start = 1'b1;
        cyc(); frame_start = 1'b0;
        check_vec("rs_pending", 2'b10, 2'd2);
        bus.vec_ready = 1'b1;
        cyc(); check("rs_drained", 32'(bus.vec_valid), 32'(0));

`ifdef STV_FLUSH_EN
        // flush a one-bit partial group
        drive(1'b1, 1'b1); cyc();
        drive(1'b0, 1'b0); flush = 1'b1;
        cyc(); flush = 1'b0;
        check_vec("fl_partial", 2'b01, 2'd1);
        flush = 1'b1;
        cyc(); flush = 1'b0;
        check("fl_empty_valid", 32'(bus.vec_valid), 32'(0));
        drive(1'b1, 1'b1); cyc();
        drive(1'b1, 1'b1); cyc(); check_vec("fl_after", 2'b11, 2'd2);
        drive(1'b0, 1'b0); cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
